result_deskew_buf: RTL and testbench

RESULT_DESKEW_BUF -- requirements
Module: result_deskew_buf

---
 rtl/result_deskew_buf.sv | 182 ++++++++++++++++++
 tb/tb_result_deskew_buf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_deskew_buf.sv
`default_nettype none
// ============================================================================
// Module      : result_deskew_buf
// Description : Captures one tile of skewed systolic-array results and
//               re-aligns it into a DIM x DIM row buffer that can be read
//               back one row at a time.
//
//   Column j of Cin arrives one en-cycle later than column j-1. Each column
//   goes through a shift register of depth DIM-1-j, so all columns of a
//   row appear together at the delay-line outputs. Those aligned rows are
//   then written into the buffer.
//
// Ports       :
//   clk      in   clock; all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   start    in   clear the buffer and begin a new tile capture
//   en       in   advance enable; one skewed wavefront per en-cycle
//   Cin      in   DIM x BITS_C skewed column results (Cin[j] = column j)
//   rd_en    in   read request; honoured only while the tile is full
//   rd_row   in   row index to read
//   Cout     out  registered row-aligned read data
//   rd_valid out  Cout was updated this cycle
//   busy     out  capture in progress (PRIME or CAPTURE)
//   full     out  tile complete, buffer readable
//
// Revision    : 1.0 - initial release
// ============================================================================
module result_deskew_buf #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          en,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  input  logic                          rd_en,
  input  logic [$clog2(DIM)-1:0]        rd_row,
  output logic [DIM-1:0][BITS_C-1:0]    Cout,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          full
);

  localparam int RW = $clog2(DIM);
  localparam int KW = $clog2(2 * DIM);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRIME   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FULL    = 2'd3;

  // Last en-cycle index of the priming phase and of the whole tile.
  localparam logic [KW-1:0] K_PRIME_LAST = KW'(DIM - 2);
  localparam logic [KW-1:0] K_TILE_LAST  = KW'(2 * DIM - 2);
  localparam logic [KW-1:0] K_ROW_OFFS   = KW'(DIM - 1);

  logic [1:0]                       state;
  logic [1:0]                       state_nxt;
  logic [KW-1:0]                    k;
  logic                             adv;
  logic                             wr;
  logic [RW-1:0]                    wr_row;
  logic                             rd_fire;
  logic [DIM-1:0][BITS_C-1:0]       aligned;
  logic [DIM-1:0][BITS_C-1:0]       mem [DIM];

  // start always wins: a coincident en or rd_en is discarded.
  assign adv     = en && !start && ((state == S_PRIME) || (state == S_CAPTURE));
  assign wr      = adv && (state == S_CAPTURE);
  assign wr_row  = RW'(k - K_ROW_OFFS);
  assign rd_fire = rd_en && !start && (state == S_FULL);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_PRIME;
    end else begin
      case (state)
        S_PRIME:   if (en && (k == K_PRIME_LAST)) state_nxt = S_CAPTURE;
        S_CAPTURE: if (en && (k == K_TILE_LAST))  state_nxt = S_FULL;
        default:   state_nxt = state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    full = 1'b0;
    case (state)
      S_PRIME, S_CAPTURE: busy = 1'b1;
      S_FULL:             full = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // en-cycle counter since start
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (start) begin
      k <= '0;
    end else if (adv) begin
      k <= k + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-column deskew delay lines. Column j is delayed DIM-1-j en-cycles so
  // that at en-cycle k every column presents row k-(DIM-1).
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < DIM; j++) begin : g_col
    if (j == DIM - 1) begin : g_pass
      assign aligned[j] = Cin[j];
    end else begin : g_dly
      localparam int D = DIM - 1 - j;
      logic [BITS_C-1:0] sr [D];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (start) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= Cin[j];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end

      assign aligned[j] = sr[D-1];
    end
  end

  // --------------------------------------------------------------------------
  // Row buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) mem[r] <= '0;
    end else if (start) begin
      for (int r = 0; r < DIM; r++) mem[r] <= '0;
    end else if (wr) begin
      mem[wr_row] <= aligned;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port; Cout holds whenever no read is accepted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Cout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        Cout <= mem[rd_row];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_deskew_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_deskew_buf
// Description : Self-checking bench for result_deskew_buf (DIM=4, BITS_C=16).
//               Reads push their expected row into a queue; a monitor pops
//               and compares whenever rd_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_deskew_buf;

  localparam int BITS_C = 16;
  localparam int DIM    = 4;

  typedef logic [DIM-1:0][BITS_C-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       en = 1'b0;
  vec_t       Cin = '0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_row = '0;
  vec_t       Cout;
  logic       rd_valid;
  logic       busy;
  logic       full;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t saved;

  result_deskew_buf #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .Cin(Cin),
    .rd_en(rd_en), .rd_row(rd_row), .Cout(Cout), .rd_valid(rd_valid),
    .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  // Skewed stimulus: Cin[j] = 10*(k-j)+j+off inside the tile, else 0x7FFF.
  function automatic vec_t stim(int k, int off);
    vec_t v;
    for (int j = 0; j < DIM; j++) begin
      if ((k - j) >= 0 && (k - j) <= DIM - 1) v[j] = 16'(10 * (k - j) + j + off);
      else                                    v[j] = 16'h7FFF;
    end
    return v;
  endfunction

  function automatic vec_t row_exp(int r, int off);
    vec_t v;
    for (int j = 0; j < DIM; j++) v[j] = 16'(10 * r + j + off);
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got Cout %h with no read pending", Cout);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (Cout !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", Cout, e);
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic en_cycle(vec_t v);
    en  = 1'b1;
    Cin = v;
    @(negedge clk);
    en  = 1'b0;
    Cin = '0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(int r, vec_t e);
    rd_en  = 1'b1;
    rd_row = 2'(r);
    exp_q.push_back(e);
    @(negedge clk);
    rd_en  = 1'b0;
  endtask

  task automatic drain(string name);
    idle(2);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // ---- reset state
    idle(2);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_cout", 64'(Cout), 64'd0);
    rst = 1'b0;
    idle(1);

    // ---- basic tile
    do_start();
    for (int k = 0; k < 7; k++) begin
      chk("t1_busy_during", 64'(busy), 64'd1);
      chk("t1_full_early", 64'(full), 64'd0);
      en_cycle(stim(k, 0));
    end
    chk("t1_full", 64'(full), 64'd1);
    chk("t1_busy_done", 64'(busy), 64'd0);
    for (int r = 0; r < DIM; r++) rd(r, row_exp(r, 0));
    drain("t1_drain");

    // ---- stalls after k=2 and k=5
    do_start();
    for (int k = 0; k < 7; k++) begin
      en_cycle(stim(k, 0));
      if (k == 2 || k == 5) idle(3);
    end
    chk("t2_full", 64'(full), 64'd1);
    for (int r = DIM - 1; r >= 0; r--) rd(r, row_exp(r, 0));
    drain("t2_drain");

    // ---- read during capture is ignored, repeated reads in FULL
    do_start();
    for (int k = 0; k < 4; k++) en_cycle(stim(k, 0));
    chk("t3_capture_busy", 64'(busy), 64'd1);
    saved  = Cout;
    rd_en  = 1'b1;
    rd_row = 2'd2;
    @(negedge clk);
    rd_en  = 1'b0;
    chk("t3_no_rd_valid", 64'(rd_valid), 64'd0);
    chk("t3_cout_hold", 64'(Cout), 64'(saved));
    for (int k = 4; k < 7; k++) en_cycle(stim(k, 0));
    chk("t3_full", 64'(full), 64'd1);
    for (int n = 0; n < 3; n++) rd(2, row_exp(2, 0));
    drain("t3_drain");

    // ---- abort at k=4, restart with offset +100
    do_start();
    for (int k = 0; k < 5; k++) en_cycle(stim(k, 0));
    do_start();
    chk("t4_restart_full", 64'(full), 64'd0);
    for (int k = 0; k < 7; k++) en_cycle(stim(k, 100));
    chk("t4_full", 64'(full), 64'd1);
    rd(1, row_exp(1, 100));
    for (int r = 0; r < DIM; r++) rd(r, row_exp(r, 100));
    drain("t4_drain");

    // ---- asynchronous reset mid-capture
    do_start();
    for (int k = 0; k < 5; k++) en_cycle(stim(k, 0));
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_cout", 64'(Cout), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_full", 64'(full), 64'd0);
    chk("t5_rst_rd_valid", 64'(rd_valid), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) en_cycle(stim(k, 0));
    chk("t5_no_start_full", 64'(full), 64'd0);
    chk("t5_no_start_busy", 64'(busy), 64'd0);

    // ---- start coincident with read in FULL
    do_start();
    for (int k = 0; k < 7; k++) en_cycle(stim(k, 0));
    rd(3, row_exp(3, 0));
    drain("t6_pre_drain");
    start  = 1'b1;
    rd_en  = 1'b1;
    rd_row = 2'd1;
    @(negedge clk);
    start  = 1'b0;
    rd_en  = 1'b0;
    chk("t6_dropped_read", 64'(rd_valid), 64'd0);
    chk("t6_prime_busy", 64'(busy), 64'd1);
    chk("t6_prime_full", 64'(full), 64'd0);
    for (int k = 0; k < 7; k++) en_cycle('0);
    chk("t6_full", 64'(full), 64'd1);
    for (int r = 0; r < DIM; r++) rd(r, '0);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
